mem_lsu: RTL and testbench
==========================

Name: mem_lsu

Overview:
- RV64 memory-access stage, sitting between the ex_mem pipeline register and mem_wb.
- Receives the instruction, the ALU result and the load/store control from EX.
- For loads and stores, it runs a valid/ready transaction on the 64-bit data bus and stalls the pipeline until the bus responds.
- Drives mem_rd_data, mem_rd_addr and mem_rd_ena (plus pc/inst) to mem_wb; non-memory instructions pass straight through.

Parameters:
- AW, 64, data-bus address width.
- DW, 64, data-bus data width. Fixed at 64; other values are unsupported.

Ports:
- clk  in  1  clock
- rst  in  1  reset: synchronous, active-high
- ex_pc  in  64  instruction PC
- ex_inst  in  32  instruction word
- ex_rd_data  in  64  ALU result, or write-back data for non-memory ops
- ex_rd_addr  in  5  destination register
- ex_rd_ena  in  1  register write enable
- ex_mem_op  in  4  memory operation code (see package)
- ex_mem_addr  in  64  effective address
- ex_mem_wdata  in  64  store data (rs2)
- mem_pc  out  64  PC to mem_wb
- mem_inst  out  32  instruction to mem_wb
- mem_rd_data  out  64  write-back data
- mem_rd_addr  out  5  destination register
- mem_rd_ena  out  1  write enable
- lsu_stall_req  out  1  1 = hold all upstream stages and mem_wb
- dmem_req_valid  out  1  bus request valid
- dmem_req_ready  in  1  bus accepts request
- dmem_req_addr  out  64  doubleword-aligned address: {addr[63:3],3'b0}
- dmem_req_we  out  1  1 = store
- dmem_req_wdata  out  64  lane-aligned store data
- dmem_req_wstrb  out  8  byte strobes
- dmem_rsp_valid  in  1  response / write acknowledge
- dmem_rsp_rdata  in  64  aligned read doubleword

Behaviour:
- FSM states: IDLE, REQ, RESP, DONE. Reset puts the FSM in IDLE.
- Reset values: all dmem_* outputs 0; lsu_stall_req 0; captured data register 0.
- IDLE with ex_mem_op = MEM_NONE:
  - mem_* = ex_* combinationally.
  - lsu_stall_req = 0.
- IDLE with a memory op:
  - lsu_stall_req = 1, mem_rd_ena = 0.
  - Latch address, wdata, wstrb and op into request registers; next state REQ.
- REQ:
  - dmem_req_valid = 1; request fields are held stable until dmem_req_ready.
  - On valid && ready, go to RESP. lsu_stall_req = 1.
- RESP:
  - Wait for dmem_rsp_valid. On assertion, capture dmem_rsp_rdata and go to DONE.
  - lsu_stall_req = 1.
  - A response that arrives in the same cycle as the handshake in REQ is not possible: the bus guarantees at least one cycle of latency.
- DONE:
  - lsu_stall_req = 0.
  - mem_rd_data = extracted load value (loads) or ex_rd_data (stores).
  - mem_rd_ena = ex_rd_ena for loads, 0 for stores.
  - Next state IDLE.
- Upstream holds the ex_* inputs stable while lsu_stall_req = 1.
- Minimum load latency: 3 stall cycles, then the DONE cycle.
- Load extraction:
  - Shift the captured doubleword right by addr[2:0]*8.
  - LB/LH/LW sign-extend bit 7/15/31; LBU/LHU/LWU zero-extend; LD uses the full 64 bits.
- Store formatting:
  - wdata is replicated to the byte lanes and shifted left by addr[2:0]*8.
  - wstrb = {0x01, 0x03, 0x0F, 0xFF} for SB/SH/SW/SD, shifted left by addr[2:0], truncated to 8 bits.
- Misaligned access with the feature disabled: strobes/bytes beyond lane 7 are dropped; no error is reported.
- dmem_rsp_valid in IDLE or REQ is ignored.
- Reset in any state:
  - Returns to IDLE and drops valid/stall in the next cycle.
  - An in-flight response arriving after reset is ignored.

Optional Feature:
- Macro: YSYX22040228_LSU_MISALIGN_EN.
- Defined:
  - Adds output lsu_excp (1) and lsu_excp_cause (64).
  - In IDLE, a memory op whose address is not naturally aligned issues no bus request and no stall.
  - That cycle: lsu_excp = 1, cause = 4 (load) or 6 (store), mem_rd_ena = 0.
- Undefined: ports absent; truncation behaviour as above.

Decomposition:
- Shared defines package: MEM_NONE = 0, LB = 1, LH = 2, LW = 3, LD = 4, LBU = 5, LHU = 6, LWU = 7, SB = 8, SH = 9, SW = 10, SD = 11; FSM state encodings; exception cause constants.
- Sub-module mem_lsu_fmt (combinational): store lane/strobe generation and load extract/extend. The FSM stays in mem_lsu.

Test Plan:
- ALU op (MEM_NONE, rd = 5, data 0x1234): mem_rd_data = 0x1234 and mem_rd_ena = 1 the same cycle; stall never asserted.
- LD at 0x80000008, ready immediate, rdata 0x1122334455667788 one cycle later: stall for 3 cycles; DONE gives mem_rd_data = 0x1122334455667788, rd_ena = 1.
- LB/LBU at offset 7, rdata 0x80000000_00000000: LB → 0xFFFFFFFFFFFFFF80; LBU → 0x80.
- SH 0xBEEF at 0x80000006: wstrb = 0xC0, wdata[63:48] = 0xBEEF, we = 1; mem_rd_ena = 0 in DONE.
- ready held low 4 cycles then rsp after 2 more: valid/addr stable throughout, stall high throughout, exactly one DONE cycle.
- rst asserted in RESP, then stale rsp_valid: FSM in IDLE, stall 0, no write-back. With the feature: LW at offset 2 → lsu_excp = 1, cause 4, no dmem_req_valid.

Source files
------------

// File: rtl/mem_lsu_pkg.sv
// Shared definitions for the mem_lsu memory-access stage.
//   mem_op_e    : memory operation codes carried from EX
//   lsu_state_e : bus-transaction FSM states
//   CAUSE_*     : exception cause codes for misaligned accesses
//   helpers     : load/store classification, access size, natural-alignment test
package mem_lsu_pkg;

  typedef enum logic [3:0] {
    MEM_NONE = 4'd0,
    LB       = 4'd1,
    LH       = 4'd2,
    LW       = 4'd3,
    LD       = 4'd4,
    LBU      = 4'd5,
    LHU      = 4'd6,
    LWU      = 4'd7,
    SB       = 4'd8,
    SH       = 4'd9,
    SW       = 4'd10,
    SD       = 4'd11
  } mem_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2,
    DONE = 2'd3
  } lsu_state_e;

  localparam logic [63:0] CAUSE_LOAD_MISALIGN  = 64'd4;
  localparam logic [63:0] CAUSE_STORE_MISALIGN = 64'd6;

  function automatic logic is_load(mem_op_e op);
    return op inside {LB, LH, LW, LD, LBU, LHU, LWU};
  endfunction

  function automatic logic is_store(mem_op_e op);
    return op inside {SB, SH, SW, SD};
  endfunction

  // log2 of the access size in bytes
  function automatic logic [1:0] size_log2(mem_op_e op);
    case (op)
      LB, LBU, SB: return 2'd0;
      LH, LHU, SH: return 2'd1;
      LW, LWU, SW: return 2'd2;
      default:     return 2'd3;
    endcase
  endfunction

  function automatic logic is_misaligned(mem_op_e op, logic [2:0] offset);
    case (size_log2(op))
      2'd0:    return 1'b0;
      2'd1:    return offset[0];
      2'd2:    return |offset[1:0];
      default: return |offset;
    endcase
  endfunction

endpackage

// File: rtl/mem_lsu_if.sv
// Data-bus interface between the LSU (master) and data memory (slave).
//   req_valid/req_ready : request handshake
//   req_addr            : doubleword-aligned address
//   req_we              : 1 = store
//   req_wdata/req_wstrb : lane-aligned store data and byte strobes
//   rsp_valid/rsp_rdata : read response or write acknowledge
interface mem_lsu_if #(
  parameter int AW = 64,
  parameter int DW = 64
);
  logic            req_valid;
  logic            req_ready;
  logic [AW-1:0]   req_addr;
  logic            req_we;
  logic [DW-1:0]   req_wdata;
  logic [DW/8-1:0] req_wstrb;
  logic            rsp_valid;
  logic [DW-1:0]   rsp_rdata;

  modport master (
    output req_valid, req_addr, req_we, req_wdata, req_wstrb,
    input  req_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  req_valid, req_addr, req_we, req_wdata, req_wstrb,
    output req_ready, rsp_valid, rsp_rdata
  );
endinterface

// File: rtl/mem_lsu_fmt.sv
// Combinational data formatting for the LSU (64-bit bus only).
//   st_op/st_offset/st_data -> st_wdata/st_wstrb : store lane placement and strobes
//   ld_op/ld_offset/ld_dword -> ld_value         : load extraction and extension
// Bytes that would fall beyond lane 7 are dropped.
module mem_lsu_fmt
  import mem_lsu_pkg::*;
(
  input  mem_op_e     st_op,
  input  logic [2:0]  st_offset,
  input  logic [63:0] st_data,
  output logic [63:0] st_wdata,
  output logic [7:0]  st_wstrb,
  input  mem_op_e     ld_op,
  input  logic [2:0]  ld_offset,
  input  logic [63:0] ld_dword,
  output logic [63:0] ld_value
);

  logic [63:0] st_rep;
  logic [7:0]  st_strb_base;
  logic [63:0] ld_shifted;

  // NOTE: every signal written in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    st_rep       = st_data;
    st_strb_base = 8'h00;
    case (st_op)
      SB: begin st_rep = {8{st_data[7:0]}};  st_strb_base = 8'h01; end
      SH: begin st_rep = {4{st_data[15:0]}}; st_strb_base = 8'h03; end
      SW: begin st_rep = {2{st_data[31:0]}}; st_strb_base = 8'h0F; end
      SD: begin st_rep = st_data;            st_strb_base = 8'hFF; end
      default: ;
    endcase
    st_wdata = st_rep << {st_offset, 3'b000};
    st_wstrb = st_strb_base << st_offset;
  end

  always_comb begin
    ld_shifted = ld_dword >> {ld_offset, 3'b000};
    case (ld_op)
      LB:      ld_value = {{56{ld_shifted[7]}},  ld_shifted[7:0]};
      LH:      ld_value = {{48{ld_shifted[15]}}, ld_shifted[15:0]};
      LW:      ld_value = {{32{ld_shifted[31]}}, ld_shifted[31:0]};
      LBU:     ld_value = {56'd0, ld_shifted[7:0]};
      LHU:     ld_value = {48'd0, ld_shifted[15:0]};
      LWU:     ld_value = {32'd0, ld_shifted[31:0]};
      default: ld_value = ld_shifted;
    endcase
  end

endmodule

// File: rtl/mem_lsu.sv
// RV64 memory-access stage between ex_mem and mem_wb.
// Non-memory instructions pass straight through; loads and stores run one
// valid/ready transaction on the data bus while lsu_stall_req holds the pipe.
//   clk, rst (synchronous, active-high)
//   ex_*          : instruction, ALU result and load/store control from EX
//   mem_*         : pc/inst/write-back data to mem_wb
//   lsu_stall_req : 1 = hold upstream stages and mem_wb
//   dmem          : data-bus master port (mem_lsu_if.master)
// Optional build macro YSYX22040228_LSU_MISALIGN_EN adds lsu_excp and
// lsu_excp_cause and traps naturally misaligned accesses instead of issuing them.
// DW is fixed at 64; other values are unsupported.
module mem_lsu
  import mem_lsu_pkg::*;
#(
  parameter int AW = 64,
  parameter int DW = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] ex_pc,
  input  logic [31:0] ex_inst,
  input  logic [63:0] ex_rd_data,
  input  logic [4:0]  ex_rd_addr,
  input  logic        ex_rd_ena,
  input  logic [3:0]  ex_mem_op,
  input  logic [63:0] ex_mem_addr,
  input  logic [63:0] ex_mem_wdata,
  output logic [63:0] mem_pc,
  output logic [31:0] mem_inst,
  output logic [63:0] mem_rd_data,
  output logic [4:0]  mem_rd_addr,
  output logic        mem_rd_ena,
  output logic        lsu_stall_req,
`ifdef YSYX22040228_LSU_MISALIGN_EN
  output logic        lsu_excp,
  output logic [63:0] lsu_excp_cause,
`endif
  mem_lsu_if.master   dmem
);

  lsu_state_e state, state_n;
  mem_op_e    ex_op;
  logic       ex_is_mem;
  logic       misalign_hit;
  logic       issue;
  logic       capture;

  // Request registers, loaded once in IDLE and held until the next request
  logic [AW-1:0]   addr_q;
  logic [2:0]      off_q;
  logic            we_q;
  logic [DW-1:0]   wdata_q;
  logic [DW/8-1:0] wstrb_q;
  mem_op_e         op_q;
  logic [DW-1:0]   rdata_q;

  logic [63:0] fmt_wdata;
  logic [7:0]  fmt_wstrb;
  logic [63:0] ld_value;

  assign ex_op     = mem_op_e'(ex_mem_op);
  assign ex_is_mem = is_load(ex_op) || is_store(ex_op);

`ifdef YSYX22040228_LSU_MISALIGN_EN
  assign misalign_hit   = is_misaligned(ex_op, ex_mem_addr[2:0]);
  assign lsu_excp       = (state == IDLE) && ex_is_mem && misalign_hit;
  assign lsu_excp_cause = !lsu_excp       ? 64'd0 :
                          is_load(ex_op)  ? CAUSE_LOAD_MISALIGN : CAUSE_STORE_MISALIGN;
`else
  assign misalign_hit = 1'b0;
`endif

  mem_lsu_fmt u_fmt (
    .st_op     (ex_op),
    .st_offset (ex_mem_addr[2:0]),
    .st_data   (ex_mem_wdata),
    .st_wdata  (fmt_wdata),
    .st_wstrb  (fmt_wstrb),
    .ld_op     (op_q),
    .ld_offset (off_q),
    .ld_dword  (rdata_q),
    .ld_value  (ld_value)
  );

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      addr_q  <= '0;
      off_q   <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      wstrb_q <= '0;
      op_q    <= MEM_NONE;
      rdata_q <= '0;
    end else begin
      state <= state_n;
      if (issue) begin
        addr_q  <= {ex_mem_addr[AW-1:3], 3'b000};
        off_q   <= ex_mem_addr[2:0];
        we_q    <= is_store(ex_op);
        wdata_q <= fmt_wdata;
        wstrb_q <= fmt_wstrb;
        op_q    <= ex_op;
      end
      if (capture) rdata_q <= dmem.rsp_rdata;
    end
  end

  always_comb begin
    state_n       = state;
    issue         = 1'b0;
    capture       = 1'b0;
    lsu_stall_req = 1'b0;
    mem_rd_data   = ex_rd_data;
    mem_rd_ena    = ex_rd_ena;
    case (state)
      IDLE: begin
        if (ex_is_mem) begin
          mem_rd_ena = 1'b0;
          // A trapped misaligned access retires this cycle without touching the bus
          if (!misalign_hit) begin
            issue         = 1'b1;
            lsu_stall_req = 1'b1;
            state_n       = REQ;
          end
        end
      end
      REQ: begin
        lsu_stall_req = 1'b1;
        mem_rd_ena    = 1'b0;
        if (dmem.req_ready) state_n = RESP;
      end
      RESP: begin
        lsu_stall_req = 1'b1;
        mem_rd_ena    = 1'b0;
        if (dmem.rsp_valid) begin
          capture = 1'b1;
          state_n = DONE;
        end
      end
      DONE: begin
        if (is_load(op_q)) begin
          mem_rd_data = ld_value;
        end else begin
          mem_rd_ena = 1'b0;
        end
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  assign mem_pc      = ex_pc;
  assign mem_inst    = ex_inst;
  assign mem_rd_addr = ex_rd_addr;

  assign dmem.req_valid = (state == REQ);
  assign dmem.req_addr  = addr_q;
  assign dmem.req_we    = we_q;
  assign dmem.req_wdata = wdata_q;
  assign dmem.req_wstrb = wstrb_q;

endmodule

// File: tb/tb_mem_lsu.sv
// Self-checking bench for mem_lsu: directed vector table, reset-in-flight
// sequence, and randomized transactions against a byte-level reference model.
module tb_mem_lsu;
  import mem_lsu_pkg::*;

  localparam logic [63:0] ST_RD = 64'h0BAD_F00D_CAFE_0001;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] ex_pc, ex_rd_data, ex_mem_addr, ex_mem_wdata;
  logic [31:0] ex_inst;
  logic [4:0]  ex_rd_addr;
  logic        ex_rd_ena;
  logic [3:0]  ex_mem_op;
  logic [63:0] mem_pc, mem_rd_data;
  logic [31:0] mem_inst;
  logic [4:0]  mem_rd_addr;
  logic        mem_rd_ena, lsu_stall_req;
`ifdef YSYX22040228_LSU_MISALIGN_EN
  logic        lsu_excp;
  logic [63:0] lsu_excp_cause;
`endif

  mem_lsu_if dmem ();

  mem_lsu dut (
    .clk           (clk),
    .rst           (rst),
    .ex_pc         (ex_pc),
    .ex_inst       (ex_inst),
    .ex_rd_data    (ex_rd_data),
    .ex_rd_addr    (ex_rd_addr),
    .ex_rd_ena     (ex_rd_ena),
    .ex_mem_op     (ex_mem_op),
    .ex_mem_addr   (ex_mem_addr),
    .ex_mem_wdata  (ex_mem_wdata),
    .mem_pc        (mem_pc),
    .mem_inst      (mem_inst),
    .mem_rd_data   (mem_rd_data),
    .mem_rd_addr   (mem_rd_addr),
    .mem_rd_ena    (mem_rd_ena),
    .lsu_stall_req (lsu_stall_req),
`ifdef YSYX22040228_LSU_MISALIGN_EN
    .lsu_excp      (lsu_excp),
    .lsu_excp_cause(lsu_excp_cause),
`endif
    .dmem          (dmem)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h", name, act, exp);
    end
  endtask

  typedef struct {
    mem_op_e     op;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [63:0] rdata;
    int          rdy;       // cycles ready is held low
    int          rsp;       // RESP cycles until rsp_valid (>= 1)
    logic [63:0] exp_data;
    logic        exp_ena;
    logic [7:0]  exp_strb;
    logic [63:0] exp_wdata;
  } vec_t;

  function automatic vec_t mk(mem_op_e op, logic [63:0] addr, logic [63:0] wdata,
                              logic [63:0] rdata, int rdy, int rsp, logic [63:0] exp_data,
                              logic exp_ena, logic [7:0] exp_strb, logic [63:0] exp_wdata);
    vec_t v;
    v.op = op; v.addr = addr; v.wdata = wdata; v.rdata = rdata; v.rdy = rdy; v.rsp = rsp;
    v.exp_data = exp_data; v.exp_ena = exp_ena; v.exp_strb = exp_strb; v.exp_wdata = exp_wdata;
    return v;
  endfunction

  // ---------------- reference model (byte-level) ----------------
  function automatic int nbytes(mem_op_e op);
    case (op)
      LB, LBU, SB: return 1;
      LH, LHU, SH: return 2;
      LW, LWU, SW: return 4;
      default:     return 8;
    endcase
  endfunction

  function automatic logic [63:0] model_load(mem_op_e op, int off, logic [63:0] dword);
    logic [63:0] r = '0;
    int n = nbytes(op);
    for (int i = 0; i < n; i++)
      if (off + i < 8) r[8*i +: 8] = dword[8*(off+i) +: 8];
    if ((op == LB || op == LH || op == LW) && r[8*n-1])
      for (int b = 8*n; b < 64; b++) r[b] = 1'b1;
    return r;
  endfunction

  // Lanes from the offset upward carry the store bytes cyclically; strobes
  // cover only the first n of them.
  function automatic void model_store(mem_op_e op, int off, logic [63:0] data,
                                      output logic [63:0] wd, output logic [7:0] st);
    int n = nbytes(op);
    wd = '0;
    st = '0;
    for (int lane = off; lane < 8; lane++) begin
      wd[8*lane +: 8] = data[8*((lane-off) % n) +: 8];
      st[lane]        = (lane - off) < n;
    end
  endfunction

  // ---------------- one memory transaction ----------------
  task automatic run_txn(input vec_t v, input string tag);
    logic [63:0] exp_addr = v.addr & ~64'h7;
    logic        st = (v.op >= SB);
    logic [63:0] alu_val;
    @(negedge clk);
    ex_mem_op = v.op; ex_mem_addr = v.addr; ex_mem_wdata = v.wdata;
    ex_rd_data = ST_RD; ex_rd_addr = 5'd9; ex_rd_ena = 1'b1;
    dmem.req_ready = 1'b0;
    dmem.rsp_valid = 1'($urandom_range(0, 1));
    dmem.rsp_rdata = {$urandom, $urandom};
    #1;
    check({tag, " idle_stall"}, 64'(lsu_stall_req), 64'd1);
    check({tag, " idle_rd_ena"}, 64'(mem_rd_ena), 64'd0);
    check({tag, " idle_valid"}, 64'(dmem.req_valid), 64'd0);
    for (int k = 0; k <= v.rdy; k++) begin
      @(negedge clk);
      dmem.req_ready = (k == v.rdy);
      dmem.rsp_valid = 1'($urandom_range(0, 1));   // must be ignored in REQ
      dmem.rsp_rdata = {$urandom, $urandom};
      #1;
      check({tag, " req_valid"}, 64'(dmem.req_valid), 64'd1);
      check({tag, " req_stall"}, 64'(lsu_stall_req), 64'd1);
      check({tag, " req_addr"}, dmem.req_addr, exp_addr);
      check({tag, " req_we"}, 64'(dmem.req_we), 64'(st));
      if (st) begin
        check({tag, " req_wstrb"}, 64'(dmem.req_wstrb), 64'(v.exp_strb));
        check({tag, " req_wdata"}, dmem.req_wdata, v.exp_wdata);
      end
    end
    for (int k = 1; k <= v.rsp; k++) begin
      @(negedge clk);
      dmem.req_ready = 1'($urandom_range(0, 1));
      dmem.rsp_valid = (k == v.rsp);
      dmem.rsp_rdata = (k == v.rsp) ? v.rdata : {$urandom, $urandom};
      #1;
      check({tag, " resp_stall"}, 64'(lsu_stall_req), 64'd1);
      check({tag, " resp_valid_low"}, 64'(dmem.req_valid), 64'd0);
      check({tag, " resp_rd_ena"}, 64'(mem_rd_ena), 64'd0);
    end
    @(negedge clk);
    dmem.req_ready = 1'b0;
    dmem.rsp_valid = 1'b0;
    dmem.rsp_rdata = {$urandom, $urandom};
    #1;
    check({tag, " done_stall"}, 64'(lsu_stall_req), 64'd0);
    check({tag, " done_rd_data"}, mem_rd_data, v.exp_data);
    check({tag, " done_rd_ena"}, 64'(mem_rd_ena), 64'(v.exp_ena));
    check({tag, " done_rd_addr"}, 64'(mem_rd_addr), 64'd9);
    // Following ALU op must pass through at once: exactly one DONE cycle
    @(negedge clk);
    alu_val = {$urandom, $urandom};
    ex_mem_op = MEM_NONE; ex_rd_data = alu_val; ex_pc = {$urandom, $urandom};
    #1;
    check({tag, " post_stall"}, 64'(lsu_stall_req), 64'd0);
    check({tag, " post_rd_data"}, mem_rd_data, alu_val);
    check({tag, " post_rd_ena"}, 64'(mem_rd_ena), 64'd1);
    check({tag, " post_pc"}, mem_pc, ex_pc);
  endtask

  vec_t tbl[$];

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t v;
    mem_op_e rop;
    int off;
    logic [63:0] wd;
    logic [7:0]  sb;

    rst = 1'b1;
    ex_pc = 64'h8000_0000; ex_inst = 32'h0000_0013; ex_rd_data = '0; ex_rd_addr = '0;
    ex_rd_ena = 1'b0; ex_mem_op = MEM_NONE; ex_mem_addr = '0; ex_mem_wdata = '0;
    dmem.req_ready = 1'b0; dmem.rsp_valid = 1'b0; dmem.rsp_rdata = '0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_valid", 64'(dmem.req_valid), 64'd0);
    check("rst_stall", 64'(lsu_stall_req), 64'd0);
    check("rst_addr", dmem.req_addr, 64'd0);
    check("rst_we", 64'(dmem.req_we), 64'd0);
    check("rst_wdata", dmem.req_wdata, 64'd0);
    check("rst_wstrb", 64'(dmem.req_wstrb), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // ALU passthrough
    ex_mem_op = MEM_NONE; ex_rd_addr = 5'd5; ex_rd_data = 64'h1234; ex_rd_ena = 1'b1;
    ex_inst = 32'h0012_3456;
    #1;
    check("alu_rd_data", mem_rd_data, 64'h1234);
    check("alu_rd_ena", 64'(mem_rd_ena), 64'd1);
    check("alu_rd_addr", 64'(mem_rd_addr), 64'd5);
    check("alu_inst", 64'(mem_inst), 64'h0012_3456);
    check("alu_stall", 64'(lsu_stall_req), 64'd0);
    @(negedge clk);
    #1;
    check("alu_stall2", 64'(lsu_stall_req), 64'd0);

    // Directed vector table
    tbl.push_back(mk(LD,  64'h8000_0008, '0, 64'h1122_3344_5566_7788, 0, 1,
                     64'h1122_3344_5566_7788, 1'b1, 8'h00, '0));
    tbl.push_back(mk(LB,  64'h8000_000F, '0, 64'h8000_0000_0000_0000, 0, 1,
                     64'hFFFF_FFFF_FFFF_FF80, 1'b1, 8'h00, '0));
    tbl.push_back(mk(LBU, 64'h8000_000F, '0, 64'h8000_0000_0000_0000, 1, 1,
                     64'h0000_0000_0000_0080, 1'b1, 8'h00, '0));
    tbl.push_back(mk(SH,  64'h8000_0006, 64'h0000_0000_0000_BEEF, '0, 0, 1,
                     ST_RD, 1'b0, 8'hC0, 64'hBEEF_0000_0000_0000));
    tbl.push_back(mk(LW,  64'h8000_0004, '0, 64'h8765_4321_0000_0000, 4, 2,
                     64'hFFFF_FFFF_8765_4321, 1'b1, 8'h00, '0));
    tbl.push_back(mk(LWU, 64'h0000_0004, '0, 64'h8000_0000_0000_0000, 2, 3,
                     64'h0000_0000_8000_0000, 1'b1, 8'h00, '0));
    tbl.push_back(mk(SW,  64'h0000_1004, 64'h1111_2222_DEAD_BEEF, '0, 3, 1,
                     ST_RD, 1'b0, 8'hF0, 64'hDEAD_BEEF_0000_0000));
    tbl.push_back(mk(SB,  64'h0000_2001, 64'h0000_0000_0000_00A5, '0, 0, 2,
                     ST_RD, 1'b0, 8'h02, 64'hA5A5_A5A5_A5A5_A500));
`ifndef YSYX22040228_LSU_MISALIGN_EN
    tbl.push_back(mk(SD,  64'h0000_2003, 64'h0102_0304_0506_0708, '0, 1, 1,
                     ST_RD, 1'b0, 8'hF8, 64'h0405_0607_0800_0000));
    tbl.push_back(mk(LH,  64'h0000_3007, '0, 64'hFF00_0000_0000_0000, 0, 1,
                     64'h0000_0000_0000_00FF, 1'b1, 8'h00, '0));
`endif
    foreach (tbl[i]) run_txn(tbl[i], $sformatf("vec%0d", i));

    // Reset while waiting in RESP; a late response must be ignored
    @(negedge clk);
    ex_mem_op = LD; ex_mem_addr = 64'h100; ex_rd_ena = 1'b1; ex_rd_addr = 5'd3;
    @(negedge clk);
    dmem.req_ready = 1'b1;
    @(negedge clk);
    dmem.req_ready = 1'b0;
    #1;
    check("rr_in_resp_stall", 64'(lsu_stall_req), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    ex_mem_op = MEM_NONE; ex_rd_data = 64'h7777;
    for (int k = 0; k < 3; k++) begin
      dmem.rsp_valid = (k != 1);
      dmem.rsp_rdata = 64'hDEAD_DEAD_DEAD_DEAD;
      #1;
      check("rr_stall", 64'(lsu_stall_req), 64'd0);
      check("rr_valid", 64'(dmem.req_valid), 64'd0);
      check("rr_rd_data", mem_rd_data, 64'h7777);
      check("rr_rd_ena", 64'(mem_rd_ena), 64'd1);
      @(negedge clk);
    end
    dmem.rsp_valid = 1'b0;

    // Randomized transactions checked against the reference model
    for (int n = 0; n < 40; n++) begin
      rop = mem_op_e'($urandom_range(1, 11));
      v.op = rop;
      v.addr = {$urandom, $urandom};
`ifdef YSYX22040228_LSU_MISALIGN_EN
      v.addr = v.addr & ~64'(nbytes(rop) - 1);
`endif
      off = int'(v.addr[2:0]);
      v.wdata = {$urandom, $urandom};
      v.rdata = {$urandom, $urandom};
      v.rdy = $urandom_range(0, 3);
      v.rsp = $urandom_range(1, 3);
      if (rop >= SB) begin
        model_store(rop, off, v.wdata, wd, sb);
        v.exp_data = ST_RD; v.exp_ena = 1'b0; v.exp_strb = sb; v.exp_wdata = wd;
      end else begin
        v.exp_data = model_load(rop, off, v.rdata); v.exp_ena = 1'b1;
        v.exp_strb = '0; v.exp_wdata = '0;
      end
      run_txn(v, $sformatf("rnd%0d", n));
    end

`ifdef YSYX22040228_LSU_MISALIGN_EN
    @(negedge clk);
    ex_mem_op = LW; ex_mem_addr = 64'h8000_0002; ex_rd_ena = 1'b1;
    #1;
    check("mis_ld_excp", 64'(lsu_excp), 64'd1);
    check("mis_ld_cause", lsu_excp_cause, 64'd4);
    check("mis_ld_stall", 64'(lsu_stall_req), 64'd0);
    check("mis_ld_rd_ena", 64'(mem_rd_ena), 64'd0);
    @(negedge clk);
    ex_mem_op = SW; ex_mem_addr = 64'h8000_0006;
    #1;
    check("mis_st_valid", 64'(dmem.req_valid), 64'd0);
    check("mis_st_cause", lsu_excp_cause, 64'd6);
    @(negedge clk);
    ex_mem_op = MEM_NONE;
    #1;
    check("mis_after_valid", 64'(dmem.req_valid), 64'd0);
    check("mis_after_excp", 64'(lsu_excp), 64'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
